// File: rtl/ipd_recorder.sv
// Inter-packet delay recorder: stamps the cycle gap between successive packet starts
// into the tuser delay field of each first beat, behind a 2-entry skid buffer.
module ipd_recorder #(
    parameter int          C_M_AXIS_DATA_WIDTH  = 256,
    parameter int          C_S_AXIS_DATA_WIDTH  = 256,
    parameter int          C_M_AXIS_TUSER_WIDTH = 128,
    parameter int          C_S_AXIS_TUSER_WIDTH = 128,
    parameter int          C_TUSER_TIMESTAMP_POS = 32,
    parameter logic [31:0] C_SAT_LIMIT          = 32'hFFFFFFFF
) (
    input  logic                                axi_aclk,
    input  logic                                axi_areset,
    input  logic                                sw_rst,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    s_axis_tstrb,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser,
    input  logic                                s_axis_tlast,
    input  logic                                s_axis_tvalid,
    output logic                                s_axis_tready,

    output logic [C_M_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]    m_axis_tstrb,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
    output logic                                m_axis_tlast,
    output logic                                m_axis_tvalid,
    input  logic                                m_axis_tready,

    input  logic                                ipd_rec_en,
    output logic [31:0]                         pkt_count,
    output logic [31:0]                         sat_count,
    output logic [31:0]                         last_gap
);
    localparam int DW  = C_S_AXIS_DATA_WIDTH;
    localparam int SW  = C_S_AXIS_DATA_WIDTH / 8;
    localparam int UW  = C_S_AXIS_TUSER_WIDTH;
    localparam int POS = C_TUSER_TIMESTAMP_POS;

    logic rst;
    assign rst = axi_areset | sw_rst;

    logic [63:0]   timer;
    logic [63:0]   last_sof_time;
    logic          in_pkt;
    logic          first_pkt;

    logic          s_ready_r;
    logic          main_valid;
    logic [DW-1:0] main_data;
    logic [SW-1:0] main_strb;
    logic [UW-1:0] main_user;
    logic          main_last;
    logic          skid_valid;
    logic [DW-1:0] skid_data;
    logic [SW-1:0] skid_strb;
    logic [UW-1:0] skid_user;
    logic          skid_last;

    logic          accept;
    logic          sof;
    logic          main_free;
    logic          skid_valid_nxt;
    logic [63:0]   gap;
    logic          clip;
    logic [31:0]   stamp;
    logic [UW-1:0] tuser_in;

    // Handshake: a beat moves on either side only in a cycle where valid and ready are
    // both high; the output holds its payload and tvalid until m_axis_tready takes it.
    always_comb begin
        accept   = s_axis_tvalid & s_ready_r;
        sof      = accept & ~in_pkt;
        gap      = timer - last_sof_time;
        clip     = gap > {32'd0, C_SAT_LIMIT};
        stamp    = first_pkt ? 32'd0 : (clip ? C_SAT_LIMIT : gap[31:0]);
        tuser_in = s_axis_tuser;
        if (sof && ipd_rec_en) begin
            tuser_in[POS +: 32] = stamp;
        end
    end

    always_comb begin
        main_free      = ~main_valid | m_axis_tready;
        skid_valid_nxt = skid_valid;
        if (main_free) begin
            skid_valid_nxt = 1'b0;
        end else if (accept) begin
            skid_valid_nxt = 1'b1;
        end
    end

    // Skid only fills when main is stalled; ready is the registered inverse of skid fill.
    always_ff @(posedge axi_aclk) begin
        if (rst) begin
            s_ready_r  <= 1'b0;
            main_valid <= 1'b0;
            main_data  <= '0;
            main_strb  <= '0;
            main_user  <= '0;
            main_last  <= 1'b0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_strb  <= '0;
            skid_user  <= '0;
            skid_last  <= 1'b0;
        end else begin
            s_ready_r  <= ~skid_valid_nxt;
            skid_valid <= skid_valid_nxt;
            if (main_free) begin
                if (skid_valid) begin
                    main_valid <= 1'b1;
                    main_data  <= skid_data;
                    main_strb  <= skid_strb;
                    main_user  <= skid_user;
                    main_last  <= skid_last;
                end else if (accept) begin
                    main_valid <= 1'b1;
                    main_data  <= s_axis_tdata;
                    main_strb  <= s_axis_tstrb;
                    main_user  <= tuser_in;
                    main_last  <= s_axis_tlast;
                end else begin
                    main_valid <= 1'b0;
                end
            end else if (accept) begin
                skid_data <= s_axis_tdata;
                skid_strb <= s_axis_tstrb;
                skid_user <= tuser_in;
                skid_last <= s_axis_tlast;
            end
        end
    end

    // Any cycle with stamping disabled re-arms first_pkt, so re-enable starts from stamp 0.
    always_ff @(posedge axi_aclk) begin
        if (rst) begin
            timer         <= 64'd0;
            last_sof_time <= 64'd0;
            in_pkt        <= 1'b0;
            first_pkt     <= 1'b1;
            pkt_count     <= 32'd0;
            sat_count     <= 32'd0;
            last_gap      <= 32'd0;
        end else begin
            timer <= timer + 64'd1;
            if (accept) begin
                in_pkt <= ~s_axis_tlast;
            end
            if (sof) begin
                last_sof_time <= timer;
            end
            if (!ipd_rec_en) begin
                first_pkt <= 1'b1;
            end else if (sof) begin
                first_pkt <= 1'b0;
            end
            if (sof && ipd_rec_en) begin
                pkt_count <= pkt_count + 32'd1;
                last_gap  <= stamp;
                if (!first_pkt && clip) begin
                    sat_count <= sat_count + 32'd1;
                end
            end
        end
    end

    assign s_axis_tready = s_ready_r;
    assign m_axis_tvalid = main_valid;
    assign m_axis_tdata  = main_data;
    assign m_axis_tstrb  = main_strb;
    assign m_axis_tuser  = main_user;
    assign m_axis_tlast  = main_last;

endmodule

// File: tb/tb_ipd_recorder.sv
// Bench for ipd_recorder: directed scenarios plus randomized traffic, scored against
// a gap model built from packet-start edge indices.
module tb_ipd_recorder;
    localparam int          DW  = 256;
    localparam int          SW  = DW / 8;
    localparam int          UW  = 128;
    localparam int          POS = 32;
    localparam logic [31:0] SAT = 32'd1500;
    localparam int          W   = DW + SW + UW + 1;

    logic          axi_aclk = 1'b0;
    logic          axi_areset;
    logic          sw_rst;
    logic [DW-1:0] s_axis_tdata;
    logic [SW-1:0] s_axis_tstrb;
    logic [UW-1:0] s_axis_tuser;
    logic          s_axis_tlast;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic [SW-1:0] m_axis_tstrb;
    logic [UW-1:0] m_axis_tuser;
    logic          m_axis_tlast;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          ipd_rec_en;
    logic [31:0]   pkt_count;
    logic [31:0]   sat_count;
    logic [31:0]   last_gap;

    int            tests = 0;
    int            fails = 0;
    logic [W-1:0]  exp_q[$];
    longint        edge_n = 0;
    int            rdy_mode = 0;
    int            beats_acc = 0;
    logic          bp_done;

    // reference model state
    logic          m_in_pkt;
    logic          m_first;
    longint        m_last_sof;
    int unsigned   m_pkt;
    int unsigned   m_sat;
    logic [31:0]   m_last_gap;

    ipd_recorder #(
        .C_M_AXIS_DATA_WIDTH  (DW),
        .C_S_AXIS_DATA_WIDTH  (DW),
        .C_M_AXIS_TUSER_WIDTH (UW),
        .C_S_AXIS_TUSER_WIDTH (UW),
        .C_TUSER_TIMESTAMP_POS(POS),
        .C_SAT_LIMIT          (SAT)
    ) dut (
        .axi_aclk     (axi_aclk),
        .axi_areset   (axi_areset),
        .sw_rst       (sw_rst),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tstrb (s_axis_tstrb),
        .s_axis_tuser (s_axis_tuser),
        .s_axis_tlast (s_axis_tlast),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tstrb (m_axis_tstrb),
        .m_axis_tuser (m_axis_tuser),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .ipd_rec_en   (ipd_rec_en),
        .pkt_count    (pkt_count),
        .sat_count    (sat_count),
        .last_gap     (last_gap)
    );

    // clock / reset block
    always #5 axi_aclk = ~axi_aclk;
    always @(posedge axi_aclk) edge_n <= edge_n + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge axi_aclk);
            #1;
            case (rdy_mode)
                0:       m_axis_tready = 1'b1;
                1:       m_axis_tready = ($urandom_range(0, 3) != 0);
                default: m_axis_tready = 1'b0;
            endcase
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    function automatic logic [UW-1:0] rand_user();
        logic [UW-1:0] u;
        for (int i = 0; i < UW / 32; i++) u[i*32 +: 32] = $urandom;
        return u;
    endfunction

    task automatic model_reset();
        m_in_pkt   = 1'b0;
        m_first    = 1'b1;
        m_last_sof = 0;
        m_pkt      = 0;
        m_sat      = 0;
        m_last_gap = 32'd0;
        exp_q.delete();
    endtask

    // A packet start's stamp is the number of clock edges since the previous packet start.
    task automatic model_accept(input logic [DW-1:0] d, input logic [SW-1:0] s,
                                input logic [UW-1:0] u, input logic l);
        logic [UW-1:0]   eu;
        longint unsigned gap;
        logic [31:0]     st;
        eu = u;
        if (!m_in_pkt) begin
            gap = longint'(edge_n - m_last_sof);
            if (ipd_rec_en) begin
                if (m_first)        st = 32'd0;
                else if (gap > SAT) begin st = SAT; m_sat++; end
                else                st = gap[31:0];
                eu[POS +: 32] = st;
                m_pkt++;
                m_last_gap = st;
                m_first    = 1'b0;
            end else begin
                m_first = 1'b1;
            end
            m_last_sof = edge_n;
        end
        m_in_pkt = !l;
        beats_acc++;
        exp_q.push_back({d, s, eu, l});
    endtask

    // driver tasks
    task automatic send_beat(input logic [DW-1:0] d, input logic [SW-1:0] s,
                             input logic [UW-1:0] u, input logic l);
        int budget;
        budget = 0;
        s_axis_tdata  = d;
        s_axis_tstrb  = s;
        s_axis_tuser  = u;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        forever begin
            @(negedge axi_aclk);
            if (s_axis_tready) begin
                model_accept(d, s, u, l);
                @(posedge axi_aclk);
                #1;
                break;
            end
            @(posedge axi_aclk);
            budget++;
            if (budget > 2000) begin
                check("input_accept_timeout", 64'd0, 64'd1);
                #1;
                break;
            end
        end
        s_axis_tvalid = 1'b0;
    endtask

    task automatic send_pkt(input int len);
        for (int b = 0; b < len; b++)
            send_beat(rand_data(), SW'($urandom), rand_user(), b == len - 1);
    endtask

    task automatic wait_edge(input longint t);
        while (edge_n < t) begin
            @(posedge axi_aclk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge axi_aclk);
            #1;
        end
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 200) begin
            idle(1);
            budget++;
        end
        check("drain_queue_empty", exp_q.size(), 0);
    endtask

    task automatic do_reset(input logic use_sw);
        @(posedge axi_aclk);
        #1;
        if (use_sw) sw_rst = 1'b1;
        else        axi_areset = 1'b1;
        s_axis_tvalid = 1'b0;
        @(posedge axi_aclk);
        #1;
        sw_rst     = 1'b0;
        axi_areset = 1'b0;
        model_reset();
    endtask

    // scoreboard monitor
    logic         hold_v = 1'b0;
    logic [W-1:0] hold_d;
    always @(negedge axi_aclk) begin
        logic [W-1:0] cur;
        logic [W-1:0] exp;
        cur = {m_axis_tdata, m_axis_tstrb, m_axis_tuser, m_axis_tlast};
        if (axi_areset || sw_rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                tests++;
                if (!m_axis_tvalid || cur !== hold_d) begin
                    fails++;
                    $display("FAIL hold_stable: got valid=%b tuser=%h expected valid=1 tuser=%h",
                             m_axis_tvalid, m_axis_tuser, hold_d[UW:1]);
                end
            end
            if (m_axis_tvalid && m_axis_tready) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL beat_unexpected: got tuser=%h expected no beat", m_axis_tuser);
                end else begin
                    exp = exp_q.pop_front();
                    if (cur !== exp) begin
                        fails++;
                        $display("FAIL beat: got tuser=%h last=%b data=%h expected tuser=%h last=%b data=%h",
                                 m_axis_tuser, m_axis_tlast, m_axis_tdata,
                                 exp[UW:1], exp[0], exp[W-1 -: DW]);
                    end
                end
                hold_v = 1'b0;
            end else if (m_axis_tvalid) begin
                hold_v = 1'b1;
                hold_d = cur;
            end else begin
                hold_v = 1'b0;
            end
        end
    end

    initial begin
        longint t0;
        axi_areset    = 1'b1;
        sw_rst        = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tstrb  = '0;
        s_axis_tuser  = '0;
        s_axis_tlast  = 1'b0;
        ipd_rec_en    = 1'b1;
        model_reset();

        // reset state
        do_reset(1'b0);
        check("rst_s_tready", s_axis_tready, 0);
        check("rst_m_tvalid", m_axis_tvalid, 0);
        check("rst_m_tdata_zero", |m_axis_tdata, 0);
        check("rst_m_tuser", m_axis_tuser[63:0], 0);
        check("rst_pkt_count", pkt_count, 0);
        check("rst_sat_count", sat_count, 0);
        check("rst_last_gap", last_gap, 0);
        idle(1);
        check("s_tready_after_rst", s_axis_tready, 1);

        // back-to-back single-beat packets
        for (int i = 0; i < 4; i++) begin
            send_beat(rand_data(), SW'($urandom), rand_user(), 1'b1);
            if (i == 0) check("latency_one_cycle", m_axis_tvalid, 1);
        end
        drain();
        check("b2b_pkt_count", pkt_count, 4);
        check("b2b_last_gap", last_gap, 1);

        // 4-beat packets spaced 100 and 1000 edges apart
        do_reset(1'b0);
        t0 = edge_n + 3;
        wait_edge(t0);
        send_pkt(4);
        wait_edge(t0 + 100);
        send_pkt(4);
        wait_edge(t0 + 1100);
        send_pkt(4);
        drain();
        check("gap_last_gap", last_gap, 1000);
        check("gap_pkt_count", pkt_count, 3);

        // saturation: gaps 40 and 1600 against a 1500 ceiling
        do_reset(1'b0);
        t0 = edge_n + 3;
        wait_edge(t0);
        send_pkt(1);
        wait_edge(t0 + 40);
        send_pkt(1);
        wait_edge(t0 + 1640);
        send_pkt(1);
        drain();
        check("sat_sat_count", sat_count, 1);
        check("sat_last_gap", last_gap, SAT);

        // backpressure on an 8-beat stream
        do_reset(1'b0);
        rdy_mode = 2;
        idle(3);
        beats_acc = 0;
        bp_done   = 1'b0;
        fork
            begin
                send_pkt(8);
                bp_done = 1'b1;
            end
        join_none
        idle(6);
        check("bp_s_tready_low", s_axis_tready, 0);
        check("bp_beats_held", beats_acc, 2);
        check("bp_m_tvalid", m_axis_tvalid, 1);
        idle(14);
        rdy_mode = 0;
        for (int i = 0; i < 200 && !bp_done; i++) idle(1);
        check("bp_stream_done", bp_done, 1);
        drain();
        check("bp_beats_total", beats_acc, 8);

        // stamping disabled for two packets, then re-enabled
        do_reset(1'b0);
        ipd_rec_en = 1'b0;
        send_pkt(2);
        idle(5);
        send_pkt(3);
        drain();
        check("dis_pkt_count", pkt_count, 0);
        check("dis_last_gap", last_gap, 0);
        idle(7);
        ipd_rec_en = 1'b1;
        idle(2);
        send_pkt(2);
        idle(9);
        send_pkt(1);
        drain();
        check("reen_pkt_count", pkt_count, 2);
        check("reen_last_gap", last_gap, m_last_gap);

        // sw_rst in the middle of a 6-beat packet
        do_reset(1'b0);
        send_pkt(1);
        idle(4);
        send_pkt(1);
        send_beat(rand_data(), SW'($urandom), rand_user(), 1'b0);
        send_beat(rand_data(), SW'($urandom), rand_user(), 1'b0);
        s_axis_tdata  = rand_data();
        s_axis_tuser  = rand_user();
        s_axis_tlast  = 1'b0;
        s_axis_tvalid = 1'b1;
        sw_rst        = 1'b1;
        @(posedge axi_aclk);
        #1;
        sw_rst        = 1'b0;
        s_axis_tvalid = 1'b0;
        model_reset();
        check("swrst_m_tvalid", m_axis_tvalid, 0);
        check("swrst_pkt_count", pkt_count, 0);
        check("swrst_last_gap", last_gap, 0);
        send_pkt(3);
        drain();
        check("swrst_next_pkt_count", pkt_count, 1);
        check("swrst_next_last_gap", last_gap, 0);

        // randomized traffic with random output stalls
        do_reset(1'b0);
        rdy_mode = 1;
        for (int p = 0; p < 60; p++) begin
            ipd_rec_en = ($urandom_range(0, 5) != 0);
            send_pkt($urandom_range(1, 4));
            idle($urandom_range(0, 3));
        end
        rdy_mode = 0;
        drain();
        check("rand_pkt_count", pkt_count, m_pkt);
        check("rand_sat_count", sat_count, m_sat);
        check("rand_last_gap", last_gap, m_last_gap);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ipd_recorder.md
# ipd_recorder

Receive-side companion to the inter-packet delay generator. The block sits on the capture path between a MAC RX queue and the host DMA/monitor pipeline. It measures the cycle gap between successive packet starts and writes that gap into the 32-bit delay field of tuser on each packet's first beat. A captured trace therefore carries the timing needed to replay it through the generator. Data passes through a 2-entry skid buffer, so throughput is full rate with 1-cycle latency.

## Interface
- C_M_AXIS_DATA_WIDTH, 256, master tdata width
- C_S_AXIS_DATA_WIDTH, 256, slave tdata width (must equal master)
- C_M_AXIS_TUSER_WIDTH, 128, master tuser width
- C_S_AXIS_TUSER_WIDTH, 128, slave tuser width (must equal master)
- C_TUSER_TIMESTAMP_POS, 32, LSB of the 32-bit delay field in tuser
- C_SAT_LIMIT, 32'hFFFFFFFF, saturation ceiling for a stamped gap

Ports:
- axi_aclk  in  1  single clock
- axi_areset  in  1  reset; synchronous, active-high
- sw_rst  in  1  software reset; synchronous, active-high, same effect as axi_areset
- s_axis_tdata/tstrb/tuser/tlast  in  C_S_AXIS_DATA_WIDTH / C_S_AXIS_DATA_WIDTH/8 / C_S_AXIS_TUSER_WIDTH / 1  input stream
- s_axis_tvalid  in  1 ; s_axis_tready  out  1  input handshake
- m_axis_tdata/tstrb/tuser/tlast  out  same widths as the slave stream  output stream
- m_axis_tvalid  out  1 ; m_axis_tready  in  1  output handshake
- ipd_rec_en  in  1  enable gap stamping
- pkt_count  out  32  packets stamped, wraps at 2^32
- sat_count  out  32  stamps clipped to C_SAT_LIMIT, wraps at 2^32
- last_gap  out  32  most recent stamped value

## Operation
- Timer: 64-bit free-running cycle counter. Cleared by reset and increments every cycle. Differences are computed modulo 2^64.
- SOF detect:
  - in_pkt flag is set on an accepted non-last beat and cleared on an accepted tlast beat.
  - SOF = s_axis_tvalid & s_axis_tready & !in_pkt.
  - A single-beat packet is both SOF and EOF.
- Gap is measured at input acceptance: gap = timer − last_sof_time. last_sof_time is updated on every SOF.
- Stamp value:
  - 0 for the first SOF after reset, after sw_rst, or after ipd_rec_en rises (held in a first_pkt flag).
  - Otherwise min(gap, C_SAT_LIMIT). When clipped, sat_count increments.
- Field semantics: a stamp is the gap *preceding* its packet. Host replay software shifts stamps by one record.
- ipd_rec_en is sampled at SOF and latched for the whole packet.
  - When enabled: tuser[POS+31:POS] of the first beat is replaced. All other tuser bits and all body beats pass unchanged. pkt_count increments and last_gap updates.
  - When disabled: tuser passes unmodified, counters hold, and first_pkt is set.
- Buffering: 2-entry skid buffer (main + skid register).
  - s_axis_tready = !skid_valid (registered).
  - Beat order is preserved; no beat is dropped or duplicated.

## Timing
- Reset (either source) state: m_axis_tvalid=0, s_axis_tready=0, all m_axis_* data outputs 0, buffer entries invalid, timer/last_sof_time/in_pkt/counters/last_gap = 0, first_pkt=1.
- s_axis_tready goes to 1 on the first cycle after reset deasserts.
- Latency: a beat accepted in cycle N is presented on m_axis in cycle N+1 if the buffer was empty.
- The stamp is computed combinationally at acceptance and registered with the beat. No extra latency.
- Output handshake:
  - A beat transfers when m_axis_tvalid & m_axis_tready.
  - m_axis_* data stays stable while tvalid=1 and tready=0.
  - tvalid is never withdrawn before transfer.
- Backpressure: with m_axis_tready=0, at most 2 beats are held. s_axis_tready falls in the cycle after the second beat is accepted.
- Full throughput: with m_axis_tready held at 1, one beat per cycle is sustained.
- Simultaneous accept and emit with a full skid: the skid drains to main and s_axis_tready rises next cycle.
- Reset mid-packet: buffered beats are discarded, the partial packet is truncated, and in_pkt=0. The next accepted beat is treated as SOF with stamp 0.

## Test plan
- Back-to-back single-beat packets, one per cycle, ipd_rec_en=1, m_axis_tready=1 -> stamps 0,1,1,1; pkt_count=4; latency 1 cycle.
- 4-beat packets with SOF at cycles 10, 110, 1110 -> first-beat stamps 0, 100, 1000; body-beat tuser bit-identical to input; last_gap=1000.
- C_SAT_LIMIT=50, SOF gaps of 40 and 75 -> stamps 0, 40, 50; sat_count=1.
- m_axis_tready=0 for 20 cycles during a continuous 8-beat stream -> s_axis_tready=0 after 2 beats held; all 8 beats emitted in order after release; no loss.
- ipd_rec_en=0 for 2 packets then 1 -> the 2 packets pass with tuser unchanged and counters frozen; the first packet after re-enable is stamped 0.
- sw_rst pulsed on beat 3 of a 6-beat packet -> m_axis_tvalid=0 next cycle; counters=0; the next SOF is stamped 0 and pkt_count=1.
